// File: rtl/modn_updown_counter.sv
// modn_updown_counter: modulo-N up/down counter with load, tc pulse, threshold flag and saturating wrap count.
// Define MODCNT_ONESHOT_EN for one-shot mode (hold at terminal value instead of wrapping).
module modn_updown_counter #(
  parameter int WIDTH = 5,
  parameter int MODULUS = 17,
  parameter int THRESHOLD = 8,
  parameter int WRAP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              up_dn,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              wrap_clr,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              flag,
  output logic [WRAP_W-1:0] wraps
);
  localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] THR = (WIDTH+1)'(THRESHOLD);
  localparam logic [WIDTH-1:0] TOP = MAX[WIDTH-1:0];
  localparam logic [WRAP_W-1:0] WSAT = '1;
  if (MODULUS < 2 || MODULUS > 2**WIDTH || THRESHOLD < 0 || THRESHOLD > MODULUS - 1) begin : g_bad
    $error("modn_updown_counter: illegal MODULUS/THRESHOLD");
  end
  logic             wrap;
  logic             tc_n;
  logic [WIDTH-1:0] clamp;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] q_n;
  always_comb begin
    wrap  = en & (up_dn ? ({1'b0, q} == MAX) : (q == '0));
    clamp = ({1'b0, load_val} > MAX) ? TOP : load_val;
    step  = up_dn ? q + 1'b1 : q - 1'b1;
`ifdef MODCNT_ONESHOT_EN
    q_n   = load ? clamp : (en & ~wrap) ? step : q;
    tc_n  = ~load & en & ~wrap & (up_dn ? ({1'b0, step} == MAX) : (step == '0));
`else
    q_n   = load ? clamp : en ? (wrap ? (up_dn ? '0 : TOP) : step) : q;
    tc_n  = ~load & wrap;
`endif
  end
  // flag tracks next-state q so it lines up with q in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      tc    <= 1'b0;
      flag  <= 1'(THRESHOLD == 0);
      wraps <= '0;
    end else begin
      q     <= q_n;
      tc    <= tc_n;
      flag  <= {1'b0, q_n} >= THR;
      wraps <= wrap_clr ? '0 : (tc_n && wraps != WSAT) ? wraps + 1'b1 : wraps;
    end
  end
endmodule

// File: tb/tb_modn_updown_counter.sv
// tb_modn_updown_counter: scoreboard bench for modn_updown_counter (default params plus a WRAP_W=2 instance).
module tb_modn_updown_counter;
  localparam int MOD = 17;
  localparam int TH = 8;
  logic clk = 1'b0, reset, en, up_dn, load, wrap_clr;
  logic [4:0] load_val, q, q2;
  logic tc, flag, tc2, flag2;
  logic [3:0] wraps;
  logic [1:0] wraps2;
  int total = 0, bad = 0;
  int mq, mw, mw2, mtc;
  typedef struct {int q; int tc; int flag; int w; int w2;} exp_t;
  exp_t sb[$];

  modn_updown_counter dut (.clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .wrap_clr(wrap_clr), .q(q), .tc(tc), .flag(flag), .wraps(wraps));
  modn_updown_counter #(.WRAP_W(2)) dut2 (.clk(clk), .reset(reset), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val), .wrap_clr(wrap_clr), .q(q2), .tc(tc2), .flag(flag2),
    .wraps(wraps2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic mreset();
    mq = 0; mw = 0; mw2 = 0;
    sb.delete();
  endtask

  task automatic step(input logic e, input logic u, input logic l, input logic [4:0] lv,
                      input logic c);
    exp_t x;
    en = e; up_dn = u; load = l; load_val = lv; wrap_clr = c;
    if (l) begin
      mq = (int'(lv) > MOD - 1) ? MOD - 1 : int'(lv);
      mtc = 0;
    end else if (e) begin
`ifdef MODCNT_ONESHOT_EN
      if (u) begin
        if (mq == MOD - 1) mtc = 0;
        else begin mq++; mtc = (mq == MOD - 1); end
      end else begin
        if (mq == 0) mtc = 0;
        else begin mq--; mtc = (mq == 0); end
      end
`else
      mtc = u ? (mq == MOD - 1) : (mq == 0);
      mq = u ? (mq + 1) % MOD : (mq + MOD - 1) % MOD;
`endif
    end else mtc = 0;
    mw = c ? 0 : (mtc != 0 && mw < 15) ? mw + 1 : mw;
    mw2 = c ? 0 : (mtc != 0 && mw2 < 3) ? mw2 + 1 : mw2;
    sb.push_back('{mq, mtc, int'(mq >= TH), mw, mw2});
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      x = sb.pop_front();
      chk("q", q, x.q);
      chk("tc", tc, x.tc);
      chk("flag", flag, x.flag);
      chk("wraps", wraps, x.w);
      chk("q2", q2, x.q);
      chk("wraps2", wraps2, x.w2);
    end
  endtask

  initial begin
    en = 0; up_dn = 1; load = 0; load_val = 0; wrap_clr = 0;
    reset = 1;
    mreset();
    #12;
    chk("rst_q", q, 0);
    chk("rst_tc", tc, 0);
    chk("rst_flag", flag, 0);
    chk("rst_wraps", wraps, 0);
    reset = 0;
    repeat (16) step(1, 1, 0, 0, 0);
    chk("up_top", q, 16);
    step(1, 1, 0, 0, 0);
`ifdef MODCNT_ONESHOT_EN
    chk("os_hold", q, 16);
    chk("os_wraps", wraps, 1);
    step(1, 1, 0, 0, 0);
    chk("os_hold_tc", tc, 0);
    step(1, 0, 0, 0, 0);
    chk("os_rev", q, 15);
`else
    chk("up_wrap_q", q, 0);
    chk("up_wrap_tc", tc, 1);
    chk("up_wraps", wraps, 1);
`endif
    reset = 1;
    #2;
    mreset();
    reset = 0;
    step(1, 0, 0, 0, 0);
`ifndef MODCNT_ONESHOT_EN
    chk("dn_first", q, 16);
    chk("dn_first_tc", tc, 1);
    repeat (9) step(1, 0, 0, 0, 0);
    chk("dn_q7", q, 7);
`endif
    chk("dn_flag", flag, 0);
    step(1, 1, 1, 5'd20, 0);
    chk("clamp", q, 16);
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 5'd11, 0);
    step(1, 1, 0, 0, 0);
    chk("mid_q", q, 12);
    #2;
    reset = 1;
    #1;
    chk("async_q", q, 0);
    chk("async_flag", flag, 0);
    chk("async_tc", tc, 0);
    chk("async_wraps", wraps, 0);
    mreset();
    #1;
    reset = 0;
    repeat (5 * MOD) step(1, 1, 0, 0, 0);
`ifndef MODCNT_ONESHOT_EN
    chk("sat_w2", wraps2, 3);
    chk("sat_w", wraps, 5);
`endif
    step(1, 1, 1, 5'd16, 0);
    step(1, 1, 0, 0, 1);
    chk("clr_win", wraps, 0);
    step(1, 1, 1, 5'd5, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 1, 5'd7, 0);
    step(1, 1, 0, 0, 0);
    chk("th_q8", q, 8);
    chk("th_flag", flag, 1);
    step(1, 0, 0, 0, 0);
    repeat (80) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 9) == 0), 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 19) == 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/modn_updown_counter.md
Name: modn_updown_counter

Overview:
- Parametrised modulo-N synchronous counter, successor to the fixed 5-bit JK-based mod-17 counter.
- Counts up or down with enable, parallel load, terminal-count pulse, threshold flag and a saturating wrap counter.
- Used as the timebase/sequence counter in the lab datapath blocks.
- Pure behavioural RTL; no flip-flop primitives required.

Parameters:
- WIDTH, 5: counter width in bits.
- MODULUS, 17: count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH; elaboration error otherwise.
- THRESHOLD, 8: flag asserts while q >= THRESHOLD. Legal range 0 <= THRESHOLD <= MODULUS-1.
- WRAP_W, 4: width of the wrap-event counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  load value.
- wrap_clr  input  1  synchronous clear of wraps.
- q  output  WIDTH  current count.
- tc  output  1  one-cycle terminal-count/wrap pulse.
- flag  output  1  q >= THRESHOLD.
- wraps  output  WRAP_W  saturating count of wrap events.

Behaviour:
- Reset (async, active-high): q=0, tc=0, flag=(THRESHOLD==0), wraps=0. Reset asserted mid-count aborts the count immediately; the first count after release occurs on the first clk edge with reset low.
- Priority per clk edge: load > en > hold.
- load: q <= min(load_val, MODULUS-1), i.e. out-of-range values clamp to MODULUS-1. tc=0 that cycle. wraps unchanged.
- en & up_dn:
  - q==MODULUS-1 -> q<=0, tc<=1.
  - otherwise q<=q+1, tc<=0.
- en & ~up_dn:
  - q==0 -> q<=MODULUS-1, tc<=1.
  - otherwise q<=q-1, tc<=0.
- ~en & ~load: q holds, tc<=0.
- tc is registered and high exactly one cycle, in the same cycle q shows the wrapped value. Back-to-back wraps (MODULUS=2, continuous en) give tc high on consecutive cycles.
- flag is registered from next-state q, so it is always aligned with q: flag == (q >= THRESHOLD) in every cycle, with no lag.
- wraps increments on each cycle where tc is set and saturates at 2**WRAP_W-1 (no rollover).
  - wrap_clr: wraps <= 0.
  - wrap_clr together with a wrap event: the clear wins, wraps=0.
- Direction change takes effect on the same edge; there is no turnaround cycle.
- All arithmetic is WIDTH bits. The compare against MODULUS-1 uses a WIDTH+1-bit constant so MODULUS=2**WIDTH is legal (natural rollover point).
- Counter latency: 1 clk from en/load to new q.

Optional Feature:
- Macro: MODCNT_ONESHOT_EN.
- Defined: one-shot mode.
  - A count step that would wrap instead holds q at the terminal value (MODULUS-1 up, 0 down).
  - tc pulses once, on the step that reaches the terminal value.
  - Further en steps in the same direction are ignored: tc=0, wraps unchanged. wraps then counts completed runs.
  - Reversing up_dn, or load, re-arms the counter.
- Undefined: free-running wrap behaviour as specified above.
- Port list is identical in both builds.

Test Plan:
- Defaults; reset, then en=1 up_dn=1 for 17 clocks -> q runs 0..16 then 0; tc high only in the cycle q=0 after 16; flag high exactly for q=8..16; wraps=1.
- Down count from reset, en=1 up_dn=0 -> first edge q=16, tc=1, flag=1; q=7 gives flag=0.
- load=1 load_val=20 en=1 -> q=16 (clamped), tc=0; next edge en up -> q=0, tc=1.
- Assert reset asynchronously mid-clock while q=12 -> q=0 and flag=0 immediately, before the next edge; wraps=0.
- WRAP_W=2, 5 full up cycles -> wraps saturates at 3; wrap_clr coincident with a wrap -> wraps=0.
- MODCNT_ONESHOT_EN defined, up from 0 -> q sticks at 16, single tc, wraps=1; toggle up_dn=0 -> q=15 on the next en edge.
